// File: rtl/regfile_dump.sv
// Debug dump engine: sweeps the register file's second read port and streams
// {address, value} beats over a valid/ready handshake.
module regfile_dump #(
   parameter int NUM_REGS   = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_start,
   input  logic                  i_abort,
   output logic [ADDR_WIDTH-1:0] o_rf_read_address,
   input  logic [DATA_WIDTH-1:0] i_rf_read_data,
   output logic                  o_dump_valid,
   input  logic                  i_dump_ready,
   output logic [ADDR_WIDTH-1:0] o_dump_addr,
   output logic [DATA_WIDTH-1:0] o_dump_data,
   output logic                  o_dump_last,
   output logic                  o_busy,
   output logic                  o_done
);

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_SEND} state_t;

   localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_REGS - 1);

   state_t                  r_state, w_next;
   logic [ADDR_WIDTH-1:0]   r_idx;
   logic                    r_dump_valid;
   logic [ADDR_WIDTH-1:0]   r_dump_addr;
   logic [DATA_WIDTH-1:0]   r_dump_data;
   logic                    r_dump_last;
   logic                    r_done;
   logic                    w_hs;

   assign w_hs = (r_state == S_SEND) && r_dump_valid && i_dump_ready;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= S_IDLE;
      else          r_state <= w_next;
   end

   // abort outranks both a pending start and a same-cycle handshake
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (i_start && !i_abort) w_next = S_FETCH;
         S_FETCH: w_next = i_abort ? S_IDLE : S_SEND;
         S_SEND: begin
            if (i_abort)  w_next = S_IDLE;
            else if (w_hs) w_next = r_dump_last ? S_IDLE : S_FETCH;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_idx        <= '0;
         r_dump_valid <= 1'b0;
         r_dump_addr  <= '0;
         r_dump_data  <= '0;
         r_dump_last  <= 1'b0;
         r_done       <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: r_idx <= '0;
            S_FETCH: begin
               if (i_abort) begin
                  r_idx        <= '0;
                  r_dump_valid <= 1'b0;
               end else begin
                  r_dump_data  <= i_rf_read_data;
                  r_dump_addr  <= r_idx;
                  r_dump_last  <= (r_idx == LAST_IDX);
                  r_dump_valid <= 1'b1;
               end
            end
            S_SEND: begin
               if (i_abort) begin
                  r_idx        <= '0;
                  r_dump_valid <= 1'b0;
               end else if (w_hs) begin
                  r_dump_valid <= 1'b0;
                  // idx returns to 0 so the read port idles at address 0
                  if (r_dump_last) begin
                     r_done <= 1'b1;
                     r_idx  <= '0;
                  end else begin
                     r_idx <= r_idx + ADDR_WIDTH'(1);
                  end
               end
            end
            default: r_idx <= '0;
         endcase
      end
   end

   assign o_rf_read_address = r_idx;
   assign o_dump_valid      = r_dump_valid;
   assign o_dump_addr       = r_dump_addr;
   assign o_dump_data       = r_dump_data;
   assign o_dump_last       = r_dump_last;
   assign o_busy            = (r_state != S_IDLE);
   assign o_done            = r_done;

endmodule

// File: tb/tb_regfile_dump.sv
// Directed bench for regfile_dump: full sweep, backpressure, live write,
// abort, ignored restart and asynchronous reset mid-dump.
module tb_regfile_dump;

   logic        i_clk = 1'b0;
   logic        i_rst_n = 1'b0;
   logic        i_start = 1'b0;
   logic        i_abort = 1'b0;
   logic        i_dump_ready = 1'b0;
   logic [4:0]  o_rf_read_address, o_dump_addr;
   logic [31:0] i_rf_read_data, o_dump_data;
   logic        o_dump_valid, o_dump_last, o_busy, o_done;

   logic [31:0] rf [32];
   bit          r5_set = 1'b0;
   int          n_chk = 0;
   int          n_fail = 0;

   always #5 i_clk = ~i_clk;

   assign i_rf_read_data = rf[o_rf_read_address];

   regfile_dump #(.NUM_REGS(32), .ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_abort(i_abort),
      .o_rf_read_address(o_rf_read_address), .i_rf_read_data(i_rf_read_data),
      .o_dump_valid(o_dump_valid), .i_dump_ready(i_dump_ready),
      .o_dump_addr(o_dump_addr), .o_dump_data(o_dump_data),
      .o_dump_last(o_dump_last), .o_busy(o_busy), .o_done(o_done)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] exp_data(input int a);
      case (a)
         1:       return 32'h1;
         2:       return 32'd100;
         5:       return r5_set ? 32'h55 : 32'h0;
         31:      return 32'hDEADBEEF;
         default: return 32'h0;
      endcase
   endfunction

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_valid"}, o_dump_valid, 0);
      chk({tag, "_addr"}, o_dump_addr, 0);
      chk({tag, "_data"}, o_dump_data, 0);
      chk({tag, "_last"}, o_dump_last, 0);
      chk({tag, "_busy"}, o_busy, 0);
      chk({tag, "_done"}, o_done, 0);
      chk({tag, "_rdaddr"}, o_rf_read_address, 0);
   endtask

   // bp_addr: beat held 5 cycles with ready low; abort_addr: beat aborted
   task automatic do_dump(input int bp_addr, input int abort_addr, input bit dup_start, input bit wr5);
      int  exp_addr, beats, bp_left;
      bit  finished;
      exp_addr = 0; beats = 0; bp_left = 5; finished = 0;
      i_dump_ready = 1'b1;
      @(negedge i_clk); i_start = 1'b1;
      @(negedge i_clk); i_start = 1'b0;
      chk("busy_fetch", o_busy, 1);
      chk("valid_fetch", o_dump_valid, 0);
      chk("rdaddr_fetch", o_rf_read_address, 0);
      for (int cyc = 1; cyc <= 400 && !finished; cyc++) begin
         @(negedge i_clk);
         i_start = 1'b0;
         if (dup_start && cyc == 10) i_start = 1'b1;
         if (o_done) begin
            chk("done_busy", o_busy, 0);
            chk("done_cycle", cyc, 64 + (bp_addr >= 0 ? 5 : 0));
            chk("beat_count", beats, 32);
            @(negedge i_clk);
            chk("done_pulse", o_done, 0);
            finished = 1'b1;
         end else if (o_dump_valid) begin
            chk("beat_addr", o_dump_addr, exp_addr);
            chk("beat_data", o_dump_data, exp_data(exp_addr));
            chk("beat_last", o_dump_last, exp_addr == 31);
            chk("beat_busy", o_busy, 1);
            chk("beat_rdaddr", o_rf_read_address, exp_addr);
            if (wr5 && exp_addr == 3 && !r5_set) begin
               rf[5] = 32'h55;
               r5_set = 1'b1;
            end
            if (exp_addr == bp_addr && bp_left > 0) begin
               // corrupt the source while held: the beat must not re-sample
               if (bp_left == 5) rf[bp_addr] = 32'h222;
               i_dump_ready = 1'b0;
               bp_left--;
            end else begin
               if (exp_addr == bp_addr) rf[bp_addr] = exp_data(bp_addr);
               i_dump_ready = 1'b1;
               if (exp_addr == abort_addr) begin
                  i_abort = 1'b1;
                  @(negedge i_clk);
                  i_abort = 1'b0;
                  chk("abort_valid", o_dump_valid, 0);
                  chk("abort_busy", o_busy, 0);
                  chk("abort_done", o_done, 0);
                  chk("abort_rdaddr", o_rf_read_address, 0);
                  chk("abort_beats", beats, abort_addr);
                  repeat (3) begin
                     @(negedge i_clk);
                     chk("abort_nodone", o_done, 0);
                  end
                  finished = 1'b1;
               end else begin
                  exp_addr++;
                  beats++;
               end
            end
         end else begin
            chk("fetch_busy", o_busy, 1);
            chk("fetch_rdaddr", o_rf_read_address, exp_addr);
         end
      end
      if (!finished) chk("dump_timeout", 0, 1);
      i_start = 1'b0;
      repeat (4) begin
         @(negedge i_clk);
         chk("idle_after_valid", o_dump_valid, 0);
         chk("idle_after_busy", o_busy, 0);
      end
   endtask

   task automatic reset_mid_beat7();
      bit seen;
      seen = 1'b0;
      i_dump_ready = 1'b1;
      @(negedge i_clk); i_start = 1'b1;
      @(negedge i_clk); i_start = 1'b0;
      for (int c = 0; c < 100 && !seen; c++) begin
         @(negedge i_clk);
         if (o_dump_valid && o_dump_addr == 5'd7) seen = 1'b1;
      end
      chk("reach_beat7", seen, 1);
      #2 i_rst_n = 1'b0;
      #1 chk_idle_outputs("async_rst");
      @(negedge i_clk); i_rst_n = 1'b1;
      repeat (3) begin
         @(negedge i_clk);
         chk("post_rst_busy", o_busy, 0);
         chk("post_rst_valid", o_dump_valid, 0);
      end
   endtask

   initial begin
      for (int i = 0; i < 32; i++) rf[i] = 32'h0;
      rf[1] = 32'h1; rf[2] = 32'd100; rf[31] = 32'hDEADBEEF;
      #3 chk_idle_outputs("reset");
      @(negedge i_clk); i_rst_n = 1'b1;
      // start with abort in IDLE: abort wins
      @(negedge i_clk); i_start = 1'b1; i_abort = 1'b1;
      @(negedge i_clk); i_start = 1'b0; i_abort = 1'b0;
      chk("start_abort_busy", o_busy, 0);
      @(negedge i_clk);
      chk("start_abort_valid", o_dump_valid, 0);
      do_dump(-1, -1, 1'b0, 1'b0);
      do_dump(2, -1, 1'b0, 1'b1);
      do_dump(-1, 10, 1'b0, 1'b0);
      do_dump(-1, -1, 1'b1, 1'b0);
      reset_mid_beat7();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
